dcache_mem_arb: RTL and testbench

Single-port memory arbiter and sequencer for the data cache. It shares one memory bus between two requesters: D$ read misses and the store write buffer drain. Reads take priority for load latency. Stores win on a RAW hazard, on starvation, or during a fence. The block sits between the D$/write-buffer pair and the memory interconnect and keeps at most one memory transaction outstanding.

---
 rtl/dcache_pkg.sv | 21 ++
 rtl/dcache_mem_arb.sv | 157 +++++++++++++++
 tb/tb_dcache_mem_arb.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared types for the data-cache memory arbiter: FSM states, the captured
// memory request, and the width of the store-starvation counter.
package dcache_pkg;

    localparam int STARVE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RD_WAIT,
        FENCE
    } arb_state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

endpackage

// File: rtl/dcache_mem_arb.sv
// Arbitrates one memory bus between D$ read misses and write-buffer drains.
// Reads win for latency; stores win on RAW hazard, starvation or fence.
module dcache_mem_arb
    import dcache_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req_valid_i,
    input  logic [31:0] rd_req_addr_i,
    output logic        rd_req_ready_o,
    output logic        rd_resp_valid_o,
    output logic [31:0] rd_resp_data_o,
    input  logic        wb_valid_i,
    input  logic [31:0] wb_addr_i,
    input  logic [31:0] wb_wdata_i,
    input  logic [3:0]  wb_wstrb_i,
    output logic        wb_ready_o,
    input  logic        wb_empty_i,
    input  logic        wb_hazard_i,
    input  logic        fence_i,
    output logic        fence_done_o,
    output logic        mem_valid_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic        mem_ready_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    arb_state_e          state_q, state_d;
    mem_req_t            req_q, req_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                fence_act_q, fence_act_d;   // a drain is in progress
    logic                fence_lock_q, fence_lock_d; // fence_i must drop before re-arming
    logic                grant_rd, grant_wb;
    logic                rd_ready_d, wb_ready_d, resp_valid_d, fence_done_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d      = state_q;
        req_d        = req_q;
        starve_d     = starve_q;
        fence_act_d  = fence_act_q;
        fence_lock_d = fence_lock_q;
        grant_rd     = 1'b0;
        grant_wb     = 1'b0;
        rd_ready_d   = 1'b0;
        wb_ready_d   = 1'b0;
        resp_valid_d = 1'b0;
        fence_done_d = 1'b0;

        if (!fence_i && !fence_act_q) begin
            fence_lock_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (fence_i && !fence_lock_q) begin
                    state_d      = FENCE;
                    fence_act_d  = 1'b1;
                    fence_lock_d = 1'b1;
                end else if (rd_req_valid_i && !wb_hazard_i && (starve_q < STARVE_LIM)) begin
                    grant_rd = 1'b1;
                end else if (wb_valid_i) begin
                    grant_wb = 1'b1;
                end else if (rd_req_valid_i) begin
                    grant_rd = 1'b1;
                end
            end
            REQ: begin
                if (mem_ready_i) begin
                    if (!req_q.we)        state_d = RD_WAIT;
                    else if (fence_act_q) state_d = FENCE;
                    else                  state_d = IDLE;
                end
            end
            RD_WAIT: begin
                if (mem_rvalid_i) begin
                    resp_valid_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            FENCE: begin
                if (wb_empty_i) begin
                    fence_done_d = 1'b1;
                    fence_act_d  = 1'b0;
                    state_d      = IDLE;
                end else if (wb_valid_i) begin
                    grant_wb = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant_rd) begin
            req_d      = '{we: 1'b0, addr: rd_req_addr_i, wdata: '0, wstrb: '0};
            rd_ready_d = 1'b1;
            state_d    = REQ;
            if (wb_valid_i) begin
                starve_d = (starve_q >= STARVE_LIM) ? STARVE_LIM : starve_q + 1'b1;
            end
        end
        if (grant_wb) begin
            req_d      = '{we: 1'b1, addr: wb_addr_i, wdata: wb_wdata_i, wstrb: wb_wstrb_i};
            wb_ready_d = 1'b1;
            state_d    = REQ;
            starve_d   = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            req_q           <= '0;
            starve_q        <= '0;
            fence_act_q     <= 1'b0;
            fence_lock_q    <= 1'b0;
            rd_req_ready_o  <= 1'b0;
            wb_ready_o      <= 1'b0;
            rd_resp_valid_o <= 1'b0;
            rd_resp_data_o  <= '0;
            fence_done_o    <= 1'b0;
        end else begin
            state_q         <= state_d;
            req_q           <= req_d;
            starve_q        <= starve_d;
            fence_act_q     <= fence_act_d;
            fence_lock_q    <= fence_lock_d;
            rd_req_ready_o  <= rd_ready_d;
            wb_ready_o      <= wb_ready_d;
            rd_resp_valid_o <= resp_valid_d;
            fence_done_o    <= fence_done_d;
            if (resp_valid_d) begin
                rd_resp_data_o <= mem_rdata_i;
            end
        end
    end

    // Memory fields come straight from the request register; valid follows state.
    assign mem_valid_o = (state_q == REQ);
    assign mem_we_o    = req_q.we;
    assign mem_addr_o  = req_q.addr;
    assign mem_wdata_o = req_q.wdata;
    assign mem_wstrb_o = req_q.we ? req_q.wstrb : 4'h0;

    // A hazard implies a buffered store exists; upstream must never break that.
    hazard_needs_store: assert property (@(posedge clk) disable iff (rst)
        !(rd_req_valid_i && wb_hazard_i && !wb_valid_i));

endmodule

// File: tb/tb_dcache_mem_arb.sv
// Scoreboard bench for dcache_mem_arb: stimulus queues expected memory
// transactions, responses and fence completions; a monitor checks them in order.
module tb_dcache_mem_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_req_valid_i = 1'b0;
    logic [31:0] rd_req_addr_i = '0;
    logic        rd_req_ready_o, rd_resp_valid_o;
    logic [31:0] rd_resp_data_o;
    logic        wb_valid_i, wb_empty_i, wb_hazard_i;
    logic [31:0] wb_addr_i, wb_wdata_i;
    logic [3:0]  wb_wstrb_i;
    logic        wb_ready_o;
    logic        fence_i = 1'b0;
    logic        fence_done_o;
    logic        mem_valid_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        mem_ready_i = 1'b1;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    logic        auto_rvalid, man_rvalid = 1'b0;
    logic [31:0] auto_rdata, man_rdata = '0;
    logic        mem_auto = 1'b1;
    assign mem_rvalid_i = auto_rvalid | man_rvalid;
    assign mem_rdata_i  = man_rvalid ? man_rdata : auto_rdata;

    dcache_mem_arb #(.STARVE_MAX(2)) dut (
        .clk(clk), .rst(rst),
        .rd_req_valid_i(rd_req_valid_i), .rd_req_addr_i(rd_req_addr_i),
        .rd_req_ready_o(rd_req_ready_o), .rd_resp_valid_o(rd_resp_valid_o),
        .rd_resp_data_o(rd_resp_data_o),
        .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i), .wb_wdata_i(wb_wdata_i),
        .wb_wstrb_i(wb_wstrb_i), .wb_ready_o(wb_ready_o), .wb_empty_i(wb_empty_i),
        .wb_hazard_i(wb_hazard_i), .fence_i(fence_i), .fence_done_o(fence_done_o),
        .mem_valid_o(mem_valid_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o), .mem_ready_i(mem_ready_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    typedef enum logic [1:0] {EV_MEM, EV_RESP, EV_FDONE} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] data;
    } ev_t;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } st_t;

    ev_t         exp_q[$];
    st_t         wb_q[$];
    logic [31:0] rdata_q[$];
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic ev_t ev_mem(input logic we, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [3:0] wstrb);
        ev_t e;
        e.kind = EV_MEM; e.we = we; e.addr = addr; e.wdata = wdata; e.wstrb = wstrb; e.data = '0;
        return e;
    endfunction

    function automatic ev_t ev_other(input ev_kind_e kind, input logic [31:0] data);
        ev_t e;
        e.kind = kind; e.we = 1'b0; e.addr = '0; e.wdata = '0; e.wstrb = '0; e.data = data;
        return e;
    endfunction

    function automatic st_t st(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        st_t s;
        s.addr = addr; s.wdata = wdata; s.wstrb = wstrb;
        return s;
    endfunction

    // Compare one observed DUT event against the head of the expectation queue.
    task automatic observe(input ev_kind_e kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL spurious_event: got kind %0d with nothing expected (t=%0t)", kind, $time);
            return;
        end
        e = exp_q.pop_front();
        check("event_kind", 32'(kind), 32'(e.kind));
        if (kind == EV_MEM && e.kind == EV_MEM) begin
            check("mem_we", 32'(mem_we_o), 32'(e.we));
            check("mem_addr", mem_addr_o, e.addr);
            check("mem_wstrb", 32'(mem_wstrb_o), 32'(e.wstrb));
            if (e.we) check("mem_wdata", mem_wdata_o, e.wdata);
        end else if (kind == EV_RESP && e.kind == EV_RESP) begin
            check("rd_resp_data", rd_resp_data_o, e.data);
        end
    endtask

    // Monitor: samples on the falling edge, away from the DUT's active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (rd_req_ready_o) check("rd_ready_needs_valid", 32'(rd_req_valid_i), 32'd1);
                if (wb_ready_o)     check("wb_ready_needs_valid", 32'(wb_valid_i), 32'd1);
                if (fence_done_o)   observe(EV_FDONE);
                if (mem_valid_o && mem_ready_i) observe(EV_MEM);
                if (rd_resp_valid_o) observe(EV_RESP);
            end
        end
    end

    // Write buffer model: pops on wb_ready_o, derives empty and RAW hazard.
    initial begin
        wb_valid_i = 1'b0; wb_empty_i = 1'b1; wb_hazard_i = 1'b0;
        wb_addr_i = '0; wb_wdata_i = '0; wb_wstrb_i = '0;
        forever begin
            @(negedge clk);
            #1;
            if (wb_ready_o && wb_q.size() > 0) void'(wb_q.pop_front());
            wb_valid_i  = (wb_q.size() > 0);
            wb_empty_i  = (wb_q.size() == 0);
            wb_hazard_i = 1'b0;
            foreach (wb_q[i]) if (wb_q[i].addr[31:2] == rd_req_addr_i[31:2]) wb_hazard_i = 1'b1;
            if (wb_q.size() > 0) begin
                wb_addr_i = wb_q[0].addr; wb_wdata_i = wb_q[0].wdata; wb_wstrb_i = wb_q[0].wstrb;
            end
        end
    end

    // Memory model: returns read data three cycles after the read is accepted.
    initial begin
        auto_rvalid = 1'b0; auto_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst && mem_auto && mem_valid_o && mem_ready_i && !mem_we_o) begin
                repeat (3) @(posedge clk);
                #1;
                if (rdata_q.size() > 0) auto_rdata = rdata_q.pop_front();
                else auto_rdata = 32'h0;
                auto_rvalid = 1'b1;
                @(posedge clk);
                #1 auto_rvalid = 1'b0;
            end
        end
    end

    task automatic rd_start(input logic [31:0] addr);
        rd_req_valid_i = 1'b1;
        rd_req_addr_i  = addr;
    endtask

    task automatic rd_wait_ready();
        logic got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (rd_req_ready_o) got = 1'b1;
        end
        check("rd_ready_timeout", 32'(got), 32'd1);
    endtask

    task automatic do_read(input logic [31:0] addr);
        @(posedge clk); #1;
        rd_start(addr);
        rd_wait_ready();
    endtask

    task automatic rd_idle();
        @(posedge clk); #1;
        rd_req_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        check("rst_mem_valid", 32'(mem_valid_o), 32'd0);
        check("rst_pulses", {28'd0, rd_req_ready_o, wb_ready_o, rd_resp_valid_o, fence_done_o}, 32'd0);
        check("rst_resp_data", rd_resp_data_o, 32'd0);
        check("rst_mem_fields", {27'd0, mem_we_o, mem_wstrb_o}, 32'd0);
        check("rst_mem_addr", mem_addr_o, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Lone read.
        exp_q.push_back(ev_mem(1'b0, 32'h0000_1000, 32'h0, 4'h0));
        exp_q.push_back(ev_other(EV_RESP, 32'hDEAD_BEEF));
        rdata_q.push_back(32'hDEAD_BEEF);
        do_read(32'h0000_1000);
        rd_idle();
        wait_drain();
        repeat (3) @(negedge clk);
        check("resp_data_hold", rd_resp_data_o, 32'hDEAD_BEEF);

        // Simultaneous read and write, no hazard: read first.
        exp_q.push_back(ev_mem(1'b0, 32'h0000_0100, 32'h0, 4'h0));
        exp_q.push_back(ev_other(EV_RESP, 32'hCAFE_0100));
        exp_q.push_back(ev_mem(1'b1, 32'h0000_0200, 32'h1122_3344, 4'hF));
        rdata_q.push_back(32'hCAFE_0100);
        @(posedge clk); #1;
        wb_q.push_back(st(32'h0000_0200, 32'h1122_3344, 4'hF));
        rd_start(32'h0000_0100);
        rd_wait_ready();
        rd_idle();
        wait_drain();

        // RAW hazard with a stalled memory: the store goes first.
        exp_q.push_back(ev_mem(1'b1, 32'h0000_2004, 32'h5566_7788, 4'h3));
        exp_q.push_back(ev_mem(1'b0, 32'h0000_2006, 32'h0, 4'h0));
        exp_q.push_back(ev_other(EV_RESP, 32'h2006_2006));
        rdata_q.push_back(32'h2006_2006);
        @(posedge clk); #1;
        mem_ready_i = 1'b0;
        wb_q.push_back(st(32'h0000_2004, 32'h5566_7788, 4'h3));
        rd_start(32'h0000_2006);
        repeat (4) @(posedge clk);
        #1 mem_ready_i = 1'b1;
        rd_wait_ready();
        rd_idle();
        wait_drain();

        // Starvation limit 2: R,R,W,R,R,W.
        exp_q.push_back(ev_mem(1'b0, 32'h0000_0400, 32'h0, 4'h0));
        exp_q.push_back(ev_other(EV_RESP, 32'h4444_0400));
        exp_q.push_back(ev_mem(1'b0, 32'h0000_0404, 32'h0, 4'h0));
        exp_q.push_back(ev_other(EV_RESP, 32'h4444_0404));
        exp_q.push_back(ev_mem(1'b1, 32'h0000_0300, 32'hA5A5_A5A5, 4'hF));
        exp_q.push_back(ev_mem(1'b0, 32'h0000_0408, 32'h0, 4'h0));
        exp_q.push_back(ev_other(EV_RESP, 32'h4444_0408));
        exp_q.push_back(ev_mem(1'b0, 32'h0000_040C, 32'h0, 4'h0));
        exp_q.push_back(ev_other(EV_RESP, 32'h4444_040C));
        exp_q.push_back(ev_mem(1'b1, 32'h0000_0304, 32'h5A5A_5A5A, 4'hC));
        rdata_q.push_back(32'h4444_0400);
        rdata_q.push_back(32'h4444_0404);
        rdata_q.push_back(32'h4444_0408);
        rdata_q.push_back(32'h4444_040C);
        @(posedge clk); #1;
        wb_q.push_back(st(32'h0000_0300, 32'hA5A5_A5A5, 4'hF));
        wb_q.push_back(st(32'h0000_0304, 32'h5A5A_5A5A, 4'hC));
        rd_start(32'h0000_0400);
        rd_wait_ready();
        do_read(32'h0000_0404);
        do_read(32'h0000_0408);
        do_read(32'h0000_040C);
        rd_idle();
        wait_drain();

        // Fence with two stores and a pending read.
        exp_q.push_back(ev_mem(1'b1, 32'h0000_0500, 32'h0000_0500, 4'hF));
        exp_q.push_back(ev_mem(1'b1, 32'h0000_0504, 32'h0000_0504, 4'h1));
        exp_q.push_back(ev_other(EV_FDONE, 32'h0));
        exp_q.push_back(ev_mem(1'b0, 32'h0000_0600, 32'h0, 4'h0));
        exp_q.push_back(ev_other(EV_RESP, 32'h6666_6666));
        rdata_q.push_back(32'h6666_6666);
        @(posedge clk); #1;
        wb_q.push_back(st(32'h0000_0500, 32'h0000_0500, 4'hF));
        wb_q.push_back(st(32'h0000_0504, 32'h0000_0504, 4'h1));
        fence_i = 1'b1;
        rd_start(32'h0000_0600);
        rd_wait_ready();
        rd_idle();
        wait_drain();

        // Fence with an empty buffer: done one cycle after entering FENCE.
        exp_q.push_back(ev_other(EV_FDONE, 32'h0));
        @(posedge clk); #1 fence_i = 1'b0;
        @(posedge clk); #1 fence_i = 1'b1;
        @(negedge clk);
        check("empty_fence_c0", 32'(fence_done_o), 32'd0);
        @(negedge clk);
        check("empty_fence_c1", 32'(fence_done_o), 32'd0);
        @(negedge clk);
        check("empty_fence_done", 32'(fence_done_o), 32'd1);
        @(posedge clk); #1 fence_i = 1'b0;
        wait_drain();

        // Reset while awaiting read data; the late return is ignored.
        mem_auto = 1'b0;
        exp_q.push_back(ev_mem(1'b0, 32'h0000_0700, 32'h0, 4'h0));
        do_read(32'h0000_0700);
        @(posedge clk); #1;
        rd_req_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_rdwait_mem_valid", 32'(mem_valid_o), 32'd0);
        check("rst_rdwait_resp", 32'(rd_resp_valid_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        man_rdata = 32'hBAD0_BAD0;
        man_rvalid = 1'b1;
        @(posedge clk); #1 man_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("late_rvalid_resp", 32'(rd_resp_valid_o), 32'd0);
            check("late_rvalid_mem_valid", 32'(mem_valid_o), 32'd0);
        end
        check("late_rvalid_data", rd_resp_data_o, 32'd0);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
